// File: rtl/unidad_muldiv.sv
// Iterative RV32M multiply/divide unit: 32 shift-add or restoring-divide steps,
// then a sign/special-case adjust step, giving a fixed 33-cycle latency.
module unidad_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_ADJ  = 2'b10,
        S_DONE = 2'b11
    } state_t;

    function automatic logic [XLEN-1:0] neg_w(input logic [XLEN-1:0] v);
        return ~v + {{(XLEN-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*XLEN-1:0] neg_dw(input logic [2*XLEN-1:0] v);
        return ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
    endfunction

    state_t              state_r;
    logic [2:0]          op_r;
    logic [4:0]          rd_r;
    logic                sgn_a_r;
    logic                sgn_b_r;
    logic                div_zero_r;
    logic [XLEN-1:0]     opnd_r;
    logic [2*XLEN-1:0]   acc_r;
    logic [4:0]          cnt_r;
    logic                busy_r;
    logic                done_r;
    logic [XLEN-1:0]     result_r;

    logic                accept_s;
    logic                is_mul_s;
    logic                sgn_a_s;
    logic                sgn_b_s;
    logic [XLEN-1:0]     mag_a_s;
    logic [XLEN-1:0]     mag_b_s;
    logic [XLEN:0]       mul_sum_s;
    logic [XLEN:0]       rem_sh_s;
    logic [XLEN:0]       diff_s;
    logic [2*XLEN-1:0]   acc_next_s;
    logic [2*XLEN-1:0]   prod_neg_s;
    logic [XLEN-1:0]     quo_neg_s;
    logic [XLEN-1:0]     rem_neg_s;
    logic [XLEN-1:0]     adj_s;

    // The final DONE edge doubles as an accept slot so the issue interval stays 34.
    assign accept_s = start & ((state_r == S_IDLE) | (state_r == S_DONE));
    assign is_mul_s = ~op[2];

    // Decide which incoming operands are signed and take their magnitudes.
    always_comb begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
        case (op)
            OP_MULH, OP_DIV, OP_REM: begin
                sgn_a_s = a[XLEN-1];
                sgn_b_s = b[XLEN-1];
            end
            OP_MULHSU: begin
                sgn_a_s = a[XLEN-1];
                sgn_b_s = 1'b0;
            end
            default: begin
                sgn_a_s = 1'b0;
                sgn_b_s = 1'b0;
            end
        endcase
        if (sgn_a_s) begin
            mag_a_s = neg_w(a);
        end else begin
            mag_a_s = a;
        end
        if (sgn_b_s) begin
            mag_b_s = neg_w(b);
        end else begin
            mag_b_s = b;
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*XLEN-1:XLEN]}
                  + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        rem_sh_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
        diff_s    = rem_sh_s - {1'b0, opnd_r};
        if (!op_r[2]) begin
            acc_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end else if (!diff_s[XLEN]) begin
            acc_next_s = {diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
        end else begin
            acc_next_s = {rem_sh_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
        end
    end

    // Select and sign-correct the final value from the accumulator.
    always_comb begin
        prod_neg_s = neg_dw(acc_r);
        quo_neg_s  = neg_w(acc_r[XLEN-1:0]);
        rem_neg_s  = neg_w(acc_r[2*XLEN-1:XLEN]);
        case (op_r)
            OP_MUL: adj_s = acc_r[XLEN-1:0];
            OP_MULH, OP_MULHSU: begin
                if (sgn_a_r ^ sgn_b_r) begin
                    adj_s = prod_neg_s[2*XLEN-1:XLEN];
                end else begin
                    adj_s = acc_r[2*XLEN-1:XLEN];
                end
            end
            OP_MULHU: adj_s = acc_r[2*XLEN-1:XLEN];
            OP_DIV: begin
                // A zero divisor yields an all-ones quotient that must not be negated.
                if (div_zero_r) begin
                    adj_s = {XLEN{1'b1}};
                end else if (sgn_a_r ^ sgn_b_r) begin
                    adj_s = quo_neg_s;
                end else begin
                    adj_s = acc_r[XLEN-1:0];
                end
            end
            OP_DIVU: adj_s = acc_r[XLEN-1:0];
            OP_REM: begin
                if (sgn_a_r) begin
                    adj_s = rem_neg_s;
                end else begin
                    adj_s = acc_r[2*XLEN-1:XLEN];
                end
            end
            OP_REMU: adj_s = acc_r[2*XLEN-1:XLEN];
            default: adj_s = {XLEN{1'b0}};
        endcase
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            op_r       <= 3'b000;
            rd_r       <= 5'd0;
            sgn_a_r    <= 1'b0;
            sgn_b_r    <= 1'b0;
            div_zero_r <= 1'b0;
            opnd_r     <= {XLEN{1'b0}};
            acc_r      <= {(2*XLEN){1'b0}};
            cnt_r      <= 5'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            result_r   <= {XLEN{1'b0}};
        end else if (accept_s) begin
            state_r    <= S_CALC;
            op_r       <= op;
            rd_r       <= rd_in;
            sgn_a_r    <= sgn_a_s;
            sgn_b_r    <= sgn_b_s;
            div_zero_r <= (b == {XLEN{1'b0}});
            opnd_r     <= is_mul_s ? mag_a_s : mag_b_s;
            acc_r      <= {{XLEN{1'b0}}, (is_mul_s ? mag_b_s : mag_a_s)};
            cnt_r      <= 5'd0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_r <= S_IDLE;
                end
                S_CALC: begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'd31) begin
                        state_r <= S_ADJ;
                    end else begin
                        state_r <= S_CALC;
                    end
                end
                S_ADJ: begin
                    result_r <= adj_s;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b1;
                    state_r  <= S_DONE;
                end
                S_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign rd_out = rd_r;

endmodule

// File: tb/tb_unidad_muldiv.sv
// Directed bench for unidad_muldiv: cycle-count timing model plus arithmetic
// reference, compared every cycle, with literal expectations per operation.
module tb_unidad_muldiv;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_checks = 0;
    int n_pass   = 0;
    logic chk_en = 1'b0;

    unidad_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic straight from the RV32M definitions.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x,
                                              input logic [31:0] y);
        longint sx;
        longint sy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        p  = 64'd0;
        case (f)
            3'd0: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'({32'd0, y}); return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFFFFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
                p = sx % sy;
                return p[31:0];
            end
            3'd7: begin
                if (y == 32'd0) return x;
                return x % y;
            end
            default: return 32'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timing model: accept when free, busy for 33 edges, result and done at +33.
    int          cyc = 0;
    int          m_acc = 0;
    logic        m_active = 1'b0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_val = 32'd0;
    logic [31:0] m_result = 32'd0;
    logic [4:0]  m_rd = 5'd0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
            m_result <= 32'd0;
            m_rd     <= 5'd0;
        end else begin
            m_done <= 1'b0;
            if (m_active && cyc == m_acc + 33) begin
                m_result <= m_val;
                m_done   <= 1'b1;
                m_busy   <= 1'b0;
            end
            if (start && (!m_active || cyc >= m_acc + 34)) begin
                m_active <= 1'b1;
                m_acc    <= cyc;
                m_val    <= ref_model(op, a, b);
                m_rd     <= rd_in;
                m_busy   <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_busy));
            check("done", 32'(done), 32'(m_done));
            check("rd_out", 32'(rd_out), 32'(m_rd));
            if (m_done) check("result", result, m_result);
        end
    end

    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!done && lat < 40) begin
            if (busy) bc++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] tag, input logic [31:0] lit);
        int lat;
        int bc;
        check({name, " model"}, ref_model(f, x, y), lit);
        op = f; a = x; b = y; rd_in = tag; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 32'hDEADBEEF; b = 32'h0BADF00D; rd_in = 5'd31;
        wait_done(lat, bc);
        check({name, " latency"}, 32'(lat), 32'd33);
        check({name, " busy cycles"}, 32'(bc), 32'd33);
        check({name, " result"}, result, lit);
        check({name, " rd_out"}, 32'(rd_out), 32'(tag));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int bc;
        start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; rd_in = 5'd0; rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset rd_out", 32'(rd_out), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("MUL 7*-3",        3'd0, 32'd7,        32'hFFFFFFFD, 5'd11, 32'hFFFFFFEB);
        run_op("MULH min*min",    3'd1, 32'h80000000, 32'h80000000, 5'd1,  32'h40000000);
        run_op("MULHU max*max",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE);
        run_op("MULHSU -1*max",   3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3,  32'hFFFFFFFF);
        run_op("MULH -2*3",       3'd1, 32'hFFFFFFFE, 32'd3,        5'd4,  32'hFFFFFFFF);
        run_op("DIV -7/2",        3'd4, 32'hFFFFFFF9, 32'd2,        5'd5,  32'hFFFFFFFD);
        run_op("REM -7/2",        3'd6, 32'hFFFFFFF9, 32'd2,        5'd6,  32'hFFFFFFFF);
        run_op("DIVU 7/2",        3'd5, 32'd7,        32'd2,        5'd7,  32'd3);
        run_op("REMU 7/2",        3'd7, 32'd7,        32'd2,        5'd8,  32'd1);
        run_op("DIVU 5/0",        3'd5, 32'd5,        32'd0,        5'd9,  32'hFFFFFFFF);
        run_op("REMU 5/0",        3'd7, 32'd5,        32'd0,        5'd10, 32'd5);
        run_op("DIV -5/0",        3'd4, 32'hFFFFFFFB, 32'd0,        5'd12, 32'hFFFFFFFF);
        run_op("REM -5/0",        3'd6, 32'hFFFFFFFB, 32'd0,        5'd13, 32'hFFFFFFFB);
        run_op("DIV overflow",    3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000);
        run_op("REM overflow",    3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'd0);
        run_op("DIV 20/-6",       3'd4, 32'd20,       32'hFFFFFFFA, 5'd16, 32'hFFFFFFFD);

        // Starts at E10 and E33 are ignored; the start sampled at E34 is accepted.
        op = 3'd5; a = 32'd100; b = 32'd3; rd_in = 5'd5; start = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 34; k++) begin
            if (k == 33) begin
                check("ignored-start done", 32'(done), 32'd1);
                check("ignored-start result", result, 32'd33);
                check("ignored-start rd_out", 32'(rd_out), 32'd5);
            end
            if (k == 9 || k == 32) begin
                start = 1'b1; op = 3'd5; a = 32'd1; b = 32'd3; rd_in = 5'd9;
            end else if (k == 33) begin
                start = 1'b1; op = 3'd7; a = 32'd100; b = 32'd3; rd_in = 5'd7;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(lat, bc);
        check("E34 accept latency", 32'(lat), 32'd33);
        check("E34 accept result", result, 32'd1);
        check("E34 accept rd_out", 32'(rd_out), 32'd7);

        // Reset mid-CALC at E10 (with a competing start), restart at E11.
        op = 3'd3; a = 32'hFFFFFFFF; b = 32'd2; rd_in = 5'd12; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0; start = 1'b1; op = 3'd0; a = 32'd3; b = 32'd3; rd_in = 5'd20;
        @(negedge clk);
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset result", result, 32'd0);
        check("mid reset rd_out", 32'(rd_out), 32'd0);
        rst_n = 1'b1; op = 3'd3; a = 32'hFFFFFFFF; b = 32'd2; rd_in = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, bc);
        check("post reset latency", 32'(lat), 32'd33);
        check("post reset result", result, 32'd1);
        check("post reset rd_out", 32'(rd_out), 32'd3);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
